// File: rtl/core_mc.sv
// One cell of the cellular-automaton array: single-cycle ALU over local registers,
// coordinates and neighbours, an iterative shift-add multiplier, and a predicate flag.
module core_mc #(
  parameter int unsigned X         = 0,
  parameter int unsigned Y         = 0,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned NREGS     = 8,
  parameter int unsigned VIDEO_REG = NREGS - 1,
  parameter int unsigned MUL_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              global_enable,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        op,
  input  logic [2:0]        rd,
  input  logic [3:0]        rs1,
  input  logic [3:0]        rs2,
  input  logic [DATA_W-1:0] imm,
  input  logic              pred,
  input  logic [DATA_W-1:0] i01,
  input  logic [DATA_W-1:0] i10,
  input  logic [DATA_W-1:0] i12,
  input  logic [DATA_W-1:0] i21,
  output logic [DATA_W-1:0] i11,
  output logic [DATA_W-1:0] video,
  output logic              diverge
);

  localparam int unsigned SH_W    = $clog2(DATA_W);
  localparam int unsigned MUL_CYC = DATA_W / MUL_STEP;
  localparam int unsigned CNT_W   = $clog2(MUL_CYC + 1);

  localparam logic [3:0] OP_MOV  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SEQ  = 4'd10;
  localparam logic [3:0] OP_MIN  = 4'd11;
  localparam logic [3:0] OP_MAX  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_SETP = 4'd14;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e                         state_q, state_d;
  logic [NREGS-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic                           p_q, p_d;
  logic [DATA_W-1:0]              ma_q, ma_d, mb_q, mb_d, acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [2:0]                     mrd_q, mrd_d;

  logic [DATA_W-1:0] src_a, src_b, alu_res, step_sum, wr_data;
  logic              alu_wr, accept, exec, wr_en, slt, seq;
  logic [2:0]        wr_idx;

  function automatic logic [DATA_W-1:0] sel_src(
    input logic [3:0]                   s,
    input logic [NREGS-1:0][DATA_W-1:0] r,
    input logic [DATA_W-1:0]            im,
    input logic [DATA_W-1:0]            n10,
    input logic [DATA_W-1:0]            n12,
    input logic [DATA_W-1:0]            n01,
    input logic [DATA_W-1:0]            n21
  );
    logic [DATA_W-1:0] v;
    v = '0;
    case (s)
      4'd8:    v = '0;
      4'd9:    v = DATA_W'(X);
      4'd10:   v = DATA_W'(Y);
      4'd11:   v = n10;
      4'd12:   v = n12;
      4'd13:   v = n01;
      4'd14:   v = n21;
      4'd15:   v = im;
      default: begin
        // Unimplemented register indices read as zero.
        for (int i = 0; i < NREGS; i++) begin
          if (s == 4'(i)) v = r[i];
        end
      end
    endcase
    return v;
  endfunction

  assign src_a  = sel_src(rs1, regs_q, imm, i10, i12, i01, i21);
  assign src_b  = sel_src(rs2, regs_q, imm, i10, i12, i01, i21);
  assign accept = issue_valid & (state_q == S_IDLE) & global_enable;
  assign exec   = accept & (~pred | p_q);
  assign slt    = $signed(src_a) < $signed(src_b);
  assign seq    = src_a == src_b;

  // Single-cycle ALU result.
  always_comb begin
    alu_res = '0;
    alu_wr  = 1'b1;
    case (op)
      OP_MOV:  alu_res = src_a;
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SHL:  alu_res = src_a << src_b[SH_W-1:0];
      OP_SHR:  alu_res = src_a >> src_b[SH_W-1:0];
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, slt};
      OP_SEQ:  alu_res = {{(DATA_W-1){1'b0}}, seq};
      OP_MIN:  alu_res = slt ? src_a : src_b;
      OP_MAX:  alu_res = slt ? src_b : src_a;
      default: alu_wr  = 1'b0;
    endcase
  end

  // One shift-add step retiring MUL_STEP multiplier bits.
  always_comb begin
    step_sum = acc_q + (mb_q[0] ? ma_q : '0);
    if (MUL_STEP == 2 && mb_q[1]) step_sum = step_sum + (ma_q << 1);
  end

  // Next-state, multiplier sequencing and register write-back.
  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    p_d     = p_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mrd_d   = mrd_q;
    wr_en   = 1'b0;
    wr_idx  = rd;
    wr_data = alu_res;
    case (state_q)
      S_IDLE: begin
        if (exec) begin
          if (op == OP_MUL) begin
            ma_d    = src_a;
            mb_d    = src_b;
            acc_d   = '0;
            cnt_d   = CNT_W'(MUL_CYC);
            mrd_d   = rd;
            state_d = S_MUL;
          end else if (op == OP_SETP) begin
            p_d = |src_a;
          end else begin
            wr_en = alu_wr;
          end
        end
      end
      S_MUL: begin
        ma_d  = ma_q << MUL_STEP;
        mb_d  = mb_q >> MUL_STEP;
        acc_d = step_sum;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          wr_en   = 1'b1;
          wr_idx  = mrd_q;
          wr_data = step_sum;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Indices at or above NREGS match nothing, so such writes are dropped.
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en && wr_idx == 3'(i)) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      regs_q  <= '0;
      p_q     <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      mrd_q   <= '0;
    end else if (global_enable) begin
      state_q <= state_d;
      regs_q  <= regs_d;
      p_q     <= p_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mrd_q   <= mrd_d;
    end
  end

  assign issue_ready = (state_q == S_IDLE);
  assign i11         = regs_q[0];
  assign video       = regs_q[VIDEO_REG];
  assign diverge     = p_q;

endmodule

// File: tb/tb_core_mc.sv
// Scoreboard bench for core_mc: two cells (8 regs / 1-bit multiplier, 4 regs / 2-bit
// multiplier) run the same instruction stream against an arithmetic reference model.
module tb_core_mc;

  logic        clk = 1'b0;
  logic        rst, ge, valid, pred;
  logic [3:0]  op, rs1, rs2;
  logic [2:0]  rd;
  logic [15:0] imm, i01, i10, i12, i21;
  logic        rdy0, rdy1, dv0, dv1;
  logic [15:0] i11_0, i11_1, vid0, vid1;

  always #5 clk = ~clk;

  core_mc #(.X(3), .Y(5), .DATA_W(16), .NREGS(8), .MUL_STEP(1)) u0 (
    .clk(clk), .rst(rst), .global_enable(ge), .issue_valid(valid), .issue_ready(rdy0),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .pred(pred),
    .i01(i01), .i10(i10), .i12(i12), .i21(i21), .i11(i11_0), .video(vid0), .diverge(dv0));

  core_mc #(.X(3), .Y(5), .DATA_W(16), .NREGS(4), .MUL_STEP(2)) u1 (
    .clk(clk), .rst(rst), .global_enable(ge), .issue_valid(valid), .issue_ready(rdy1),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .pred(pred),
    .i01(i01), .i10(i10), .i12(i12), .i21(i21), .i11(i11_1), .video(vid1), .diverge(dv1));

  typedef struct {
    logic [15:0] r0;
    logic [15:0] vid;
    logic        p;
    int          lat;
  } exp_t;

  exp_t        q0[$], q1[$];
  int          n_checks = 0, n_fail = 0, bc0 = 0, bc1 = 0;
  logic [15:0] m_regs [2][8];
  logic        m_p [2];
  int          nregs [2] = '{8, 4};
  int          stepw [2] = '{1, 2};
  int          vidx  [2] = '{7, 3};

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h required %0h at %0t", name, d, act, req, $time);
    end
  endtask

  function automatic logic [15:0] src(input int d, input logic [3:0] s, input logic [15:0] im);
    if (s < 4'd8) return (int'(s) < nregs[d]) ? m_regs[d][s[2:0]] : 16'd0;
    case (s)
      4'd9:    return 16'd3;
      4'd10:   return 16'd5;
      4'd11:   return i10;
      4'd12:   return i12;
      4'd13:   return i01;
      4'd14:   return i21;
      4'd15:   return im;
      default: return 16'd0;
    endcase
  endfunction

  // Reference model: applies one accepted instruction and returns the expected snapshot.
  function automatic exp_t model(input int d, input int drop);
    logic [15:0] a, b, r;
    logic        has;
    exp_t        e;
    a = src(d, rs1, imm);
    b = src(d, rs2, imm);
    r = 16'd0;
    has = 1'b1;
    e.lat = 0;
    if (!pred || m_p[d]) begin
      case (op)
        4'd1:  r = a;
        4'd2:  r = a + b;
        4'd3:  r = a - b;
        4'd4:  r = a & b;
        4'd5:  r = a | b;
        4'd6:  r = a ^ b;
        4'd7:  r = a << b[3:0];
        4'd8:  r = a >> b[3:0];
        4'd9:  r = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        4'd10: r = (a == b) ? 16'd1 : 16'd0;
        4'd11: r = ($signed(a) < $signed(b)) ? a : b;
        4'd12: r = ($signed(a) > $signed(b)) ? a : b;
        4'd13: begin r = a * b; e.lat = 16 / stepw[d] + drop; end
        4'd14: begin m_p[d] = (a != 16'd0); has = 1'b0; end
        default: has = 1'b0;
      endcase
      if (has && int'(rd) < nregs[d]) m_regs[d][rd] = r;
    end
    e.r0  = m_regs[d][0];
    e.vid = m_regs[d][vidx[d]];
    e.p   = m_p[d];
    return e;
  endfunction

  // Monitor: counts busy cycles and checks the visible state whenever a cell is ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      bc0 = 0;
      bc1 = 0;
    end else begin
      if (rdy0 !== 1'b1) bc0++;
      else if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("i11", 0, 32'(i11_0), 32'(e.r0));
        chk("video", 0, 32'(vid0), 32'(e.vid));
        chk("diverge", 0, 32'(dv0), 32'(e.p));
        if (e.lat >= 0) chk("busy_cycles", 0, bc0, e.lat);
        bc0 = 0;
      end
      if (rdy1 !== 1'b1) bc1++;
      else if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("i11", 1, 32'(i11_1), 32'(e.r0));
        chk("video", 1, 32'(vid1), 32'(e.vid));
        chk("diverge", 1, 32'(dv1), 32'(e.p));
        if (e.lat >= 0) chk("busy_cycles", 1, bc1, e.lat);
        bc1 = 0;
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
    end while (!(rdy0 === 1'b1 && rdy1 === 1'b1 && q0.size() == 0 && q1.size() == 0) && guard < 300);
    if (guard >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got busy after %0d cycles required idle", guard);
      q0.delete();
      q1.delete();
    end
  endtask

  // pre: cycles with valid high but global_enable low; drop: enable gap inside a MUL.
  task automatic issue(input logic [3:0] o, input logic [2:0] d, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [15:0] im, input logic pr,
                       input int pre, input int drop);
    exp_t e0, e1;
    wait_idle();
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; pred = pr;
    valid = 1'b1;
    ge = (pre == 0);
    repeat (pre) @(negedge clk);
    ge = 1'b1;
    @(posedge clk);
    #1;
    e0 = model(0, drop);
    e1 = model(1, drop);
    q0.push_back(e0);
    q1.push_back(e1);
    valid = 1'b0;
    if (drop > 0) begin
      repeat (2) @(negedge clk);
      ge = 1'b0;
      repeat (drop) @(negedge clk);
      ge = 1'b1;
    end
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) m_regs[d][i] = 16'd0;
      m_p[d] = 1'b0;
    end
    e = '{r0: 16'd0, vid: 16'd0, p: 1'b0, lat: -1};
    q0.push_back(e);
    q1.push_back(e);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ge = 1'b1; valid = 1'b0; pred = 1'b0;
    op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    i01 = 16'h0101; i10 = 16'h1010; i12 = 16'd200; i21 = 16'h2121;
    repeat (3) @(negedge clk);
    do_reset();

    issue(4'd1, 3'd0, 4'd15, 4'd0, 16'h1234, 1'b0, 0, 0);   // MOV r0 <- imm
    issue(4'd2, 3'd1, 4'd9, 4'd10, 16'h0, 1'b0, 0, 0);      // ADD r1 <- X+Y
    issue(4'd3, 3'd2, 4'd8, 4'd1, 16'h0, 1'b0, 0, 0);       // SUB r2 <- 0-r1
    issue(4'd9, 3'd3, 4'd2, 4'd1, 16'h0, 1'b0, 0, 0);       // SLT r3 <- r2<r1
    issue(4'd1, 3'd0, 4'd2, 4'd0, 16'h0, 1'b0, 0, 0);       // MOV r0 <- r2
    issue(4'd13, 3'd0, 4'd15, 4'd12, 16'd300, 1'b0, 0, 0);  // MUL r0 <- 300*200
    issue(4'd1, 3'd0, 4'd8, 4'd0, 16'h0, 1'b0, 0, 0);
    issue(4'd13, 3'd0, 4'd15, 4'd12, 16'd300, 1'b0, 0, 3);  // MUL with 3-cycle stall
    issue(4'd13, 3'd3, 4'd15, 4'd12, 16'd300, 1'b0, 0, 0);  // MUL aborted by reset
    repeat (4) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    issue(4'd1, 3'd0, 4'd3, 4'd0, 16'h0, 1'b0, 0, 0);       // r3 must still be 0

    issue(4'd1, 3'd1, 4'd15, 4'd0, 16'd11, 1'b0, 0, 0);
    issue(4'd14, 3'd0, 4'd8, 4'd0, 16'h0, 1'b0, 0, 0);      // SETP a=0
    issue(4'd2, 3'd1, 4'd1, 4'd15, 16'd5, 1'b1, 0, 0);      // predicated ADD skipped
    issue(4'd1, 3'd0, 4'd1, 4'd0, 16'h0, 1'b0, 0, 0);
    issue(4'd14, 3'd0, 4'd15, 4'd0, 16'd7, 1'b0, 0, 0);     // SETP a=7
    issue(4'd13, 3'd3, 4'd15, 4'd12, 16'd300, 1'b1, 0, 0);  // predicated MUL runs
    issue(4'd1, 3'd6, 4'd15, 4'd0, 16'd9, 1'b0, 0, 0);      // r6 dropped on 4-reg cell
    issue(4'd1, 3'd0, 4'd6, 4'd0, 16'h0, 1'b0, 0, 0);
    issue(4'd1, 3'd3, 4'd15, 4'd0, 16'hBEEF, 1'b0, 2, 0);   // accept held off by enable

    for (int n = 0; n < 300; n++) begin
      logic [3:0] o;
      int         pre, drop;
      o = 4'($urandom_range(0, 15));
      pre = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      drop = (o == 4'd13 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      i01 = 16'($urandom); i10 = 16'($urandom); i12 = 16'($urandom); i21 = 16'($urandom);
      issue(o, 3'($urandom), 4'($urandom), 4'($urandom), 16'($urandom),
            ($urandom_range(0, 3) == 0), pre, drop);
    end

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
